// File: rtl/calc_operand_loader.sv
// Byte-stream front end for the adder-subtractor: assembles CMD/P/Q frames, guarded by sync and inter-byte timeout.
// Optional trailing XOR checksum byte when CALC_CHECKSUM_EN is defined.
module calc_operand_loader #(
    parameter int         TIMEOUT = 1000,
    parameter int         CNT_W   = 16,
    parameter logic [3:0] SYNC    = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  Command,
    output logic [15:0] inputP,
    output logic [15:0] inputQ,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, P_HI, P_LO, Q_HI, Q_LO, CHK, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             acc, in_frame, tmo, load, err_nx;
    logic [3:0]       cmd_sh;
    logic [15:0]      p_sh, q_sh;
`ifdef CALC_CHECKSUM_EN
    logic [7:0]       chk_sh;
`endif

    assign in_ready = (state != HOLD);
    assign op_valid = (state == HOLD);
    assign busy     = (state != IDLE);
    assign acc      = in_valid && in_ready;
    assign in_frame = (state != IDLE) && (state != HOLD);
    // An accepted byte on the final count cycle beats the abort.
    assign tmo      = in_frame && !acc && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (in_data[7:4] == SYNC) state_nx = P_HI;
                    else                      err_nx   = 1'b1;
                end
            end
            P_HI: if (acc) state_nx = P_LO;
            P_LO: if (acc) state_nx = Q_HI;
            Q_HI: if (acc) state_nx = Q_LO;
            Q_LO: begin
                if (acc) begin
`ifdef CALC_CHECKSUM_EN
                    state_nx = CHK;
`else
                    state_nx = HOLD;
                    load     = 1'b1;
`endif
                end
            end
            CHK: begin
`ifdef CALC_CHECKSUM_EN
                if (acc) begin
                    if (in_data == chk_sh) begin
                        state_nx = HOLD;
                        load     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end
                end
`else
                state_nx = IDLE;
`endif
            end
            HOLD: if (op_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (tmo) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            cmd_sh    <= '0;
            p_sh      <= '0;
            q_sh      <= '0;
            Command   <= '0;
            inputP    <= '0;
            inputQ    <= '0;
`ifdef CALC_CHECKSUM_EN
            chk_sh    <= '0;
`endif
        end else begin
            frame_err <= err_nx;
            if (in_frame && !acc && !tmo) cnt <= cnt + 1'b1;
            else                          cnt <= '0;

            if (acc) begin
                case (state)
                    IDLE: if (in_data[7:4] == SYNC) cmd_sh <= in_data[3:0];
                    P_HI: p_sh[15:8] <= in_data;
                    P_LO: p_sh[7:0]  <= in_data;
                    Q_HI: q_sh[15:8] <= in_data;
                    Q_LO: q_sh[7:0]  <= in_data;
                    default: ;
                endcase
`ifdef CALC_CHECKSUM_EN
                if (state == IDLE) chk_sh <= in_data;
                else               chk_sh <= chk_sh ^ in_data;
`endif
            end

            // Q_LO byte is still in flight when loading without a checksum stage.
            if (load) begin
                Command <= cmd_sh;
                inputP  <= p_sh;
                inputQ  <= (state == Q_LO) ? {q_sh[15:8], in_data} : q_sh;
            end
        end
    end

endmodule

// File: tb/tb_calc_operand_loader.sv
// Directed bench for calc_operand_loader: frame load, sync reject, timeout boundary, reset, HOLD back-pressure.
module tb_calc_operand_loader;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Command;
    logic [15:0] inputP, inputQ;
    logic        op_valid, op_ready, frame_err, busy;

    int checks = 0;
    int errors = 0;

    calc_operand_loader #(.TIMEOUT(TO), .CNT_W(16), .SYNC(4'hA)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .Command(Command), .inputP(inputP), .inputQ(inputQ),
        .op_valid(op_valid), .op_ready(op_ready), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] pl,
                              input logic [7:0] qh, input logic [7:0] ql);
        send(c); send(ph); send(pl); send(qh); send(ql);
`ifdef CALC_CHECKSUM_EN
        send(c ^ ph ^ pl ^ qh ^ ql);
`endif
    endtask

    task automatic release_frame();
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; op_ready = 1'b0;
        tick(2);
        chk("rst_cmd", 32'(Command), 32'h0);
        chk("rst_p", 32'(inputP), 32'h0);
        chk("rst_q", 32'(inputQ), 32'h0);
        chk("rst_opv", 32'(op_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdy", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        tick(1);

        // Basic frame, held with op_ready low
        send(8'hA3); send(8'h00); send(8'h07); send(8'h00);
`ifdef CALC_CHECKSUM_EN
        send(8'h02);
        chk("pre_opv", 32'(op_valid), 32'h0);
        send(8'hA6);
`else
        chk("pre_opv", 32'(op_valid), 32'h0);
        send(8'h02);
`endif
        chk("f1_opv", 32'(op_valid), 32'h1);
        chk("f1_cmd", 32'(Command), 32'h3);
        chk("f1_p", 32'(inputP), 32'h0007);
        chk("f1_q", 32'(inputQ), 32'h0002);
        chk("f1_rdy", 32'(in_ready), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("f1_hold", {op_valid, 3'b0, Command, inputP, inputQ[7:0]}, {1'b1, 3'b0, 4'h3, 16'h0007, 8'h02});
        end
        release_frame();
        chk("f1_rel_opv", 32'(op_valid), 32'h0);
        chk("f1_rel_busy", 32'(busy), 32'h0);

        // Non-sync byte rejected
        send(8'h53);
        chk("sync_err", 32'(frame_err), 32'h1);
        chk("sync_busy", 32'(busy), 32'h0);
        chk("sync_cmd", 32'(Command), 32'h3);
        tick(1);
        chk("sync_err_1cyc", 32'(frame_err), 32'h0);
        send_frame(8'hA0, 8'h12, 8'h34, 8'h56, 8'h78);
        chk("f2_opv", 32'(op_valid), 32'h1);
        chk("f2_cmd", 32'(Command), 32'h0);
        chk("f2_p", 32'(inputP), 32'h1234);
        chk("f2_q", 32'(inputQ), 32'h5678);
        release_frame();

        // Timeout: still waiting one cycle before the limit, aborted at it
        send(8'hA0); send(8'h11);
        tick(TO - 1);
        chk("to_pre_busy", 32'(busy), 32'h1);
        chk("to_pre_err", 32'(frame_err), 32'h0);
        tick(1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_err", 32'(frame_err), 32'h1);
        chk("to_opv", 32'(op_valid), 32'h0);
        chk("to_p_kept", 32'(inputP), 32'h1234);
        tick(1);
        chk("to_err_1cyc", 32'(frame_err), 32'h0);
        send_frame(8'hA5, 8'hAB, 8'hCD, 8'h01, 8'h23);
        chk("f3_cmd", 32'(Command), 32'h5);
        chk("f3_p", 32'(inputP), 32'hABCD);
        chk("f3_q", 32'(inputQ), 32'h0123);
        release_frame();

        // Byte on the final count cycle wins over timeout
        send(8'hA9); send(8'h11);
        tick(TO - 1);
        send(8'h22);
        chk("win_busy", 32'(busy), 32'h1);
        chk("win_err", 32'(frame_err), 32'h0);
        send(8'h00);
`ifdef CALC_CHECKSUM_EN
        send(8'h01); send(8'hA9 ^ 8'h11 ^ 8'h22 ^ 8'h00 ^ 8'h01);
`else
        send(8'h01);
`endif
        chk("win_opv", 32'(op_valid), 32'h1);
        chk("win_p", 32'(inputP), 32'h1122);
        chk("win_q", 32'(inputQ), 32'h0001);
        release_frame();

        // Reset mid-frame
        send(8'hA7); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mrst_cmd", 32'(Command), 32'h0);
        chk("mrst_p", 32'(inputP), 32'h0);
        chk("mrst_q", 32'(inputQ), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_rdy", 32'(in_ready), 32'h1);
        send(8'h03);
        chk("mrst_err_a", 32'(frame_err), 32'h1);
        chk("mrst_idle_a", 32'(busy), 32'h0);
        send(8'h04);
        chk("mrst_err_b", 32'(frame_err), 32'h1);
        tick(1);
        chk("mrst_err_clr", 32'(frame_err), 32'h0);

        // in_valid held during HOLD waits upstream
        send_frame(8'hA3, 8'h00, 8'h07, 8'h00, 8'h02);
        in_data = 8'hA1; in_valid = 1'b1;
        tick(3);
        chk("hold_rdy", 32'(in_ready), 32'h0);
        chk("hold_opv", 32'(op_valid), 32'h1);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("hold_idle_busy", 32'(busy), 32'h0);
        chk("hold_idle_rdy", 32'(in_ready), 32'h1);
        tick(1);
        in_valid = 1'b0;
        chk("hold_acc_busy", 32'(busy), 32'h1);
        send(8'h00); send(8'h00); send(8'h00);
`ifdef CALC_CHECKSUM_EN
        send(8'h00); send(8'hA1);
`else
        send(8'h00);
`endif
        chk("hold_f_cmd", 32'(Command), 32'h1);
        chk("hold_f_p", 32'(inputP), 32'h0000);
        release_frame();

`ifdef CALC_CHECKSUM_EN
        // Bad checksum dropped, outputs untouched
        send(8'hA3); send(8'h00); send(8'h07); send(8'h00); send(8'h02); send(8'h00);
        chk("cs_err", 32'(frame_err), 32'h1);
        chk("cs_opv", 32'(op_valid), 32'h0);
        chk("cs_busy", 32'(busy), 32'h0);
        chk("cs_cmd", 32'(Command), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
